// File: rtl/echo_pkg.sv
// Shared types and default widths for the echo delay-line controller.
package echo_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        XFER  = 2'd3
    } state_t;

endpackage

// File: rtl/echo_delay_controller_if.sv
// Single-port RAM bus between the delay-line controller (master) and the external RAM (slave).
interface echo_delay_controller_if
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/echo_ring_pointer.sv
// Circular write pointer, programmable length and post-reset clear counter for the delay RAM.
module echo_ring_pointer
    import echo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic              load,
    input  logic [ADDR_W-1:0] delay_len,
    output logic [ADDR_W-1:0] wp,
    output logic [ADDR_W-1:0] clr_cnt,
    output logic              clr_last
);

    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] wp_inc;
    logic [ADDR_W-1:0] new_len;

    always_comb begin
        wp_inc  = wp + ADDR_W'(1);
        new_len = (delay_len == '0) ? ADDR_W'(1) : delay_len;
    end

    assign clr_last = (clr_cnt == '1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp      <= '0;
            len     <= '1;
            clr_cnt <= '0;
        end else begin
            if (clear) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
            if (advance) begin
                wp <= (wp_inc == len) ? '0 : wp_inc;
            end else if (load) begin
                // A shorter line must not leave the pointer beyond its new end.
                len <= new_len;
                if (wp >= new_len) begin
                    wp <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/echo_delay_controller.sv
// Sequences an external single-port RAM as a programmable circular delay line:
// read oldest sample, overwrite slot with new feedback sample, present delayed sample.
module echo_delay_controller
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic [DATA_W-1:0]       sample_in,
    input  logic [ADDR_W-1:0]       delay_len,
    input  logic                    cfg_load,
    output logic                    busy,
    output logic [DATA_W-1:0]       delayed_out,
    output logic                    delayed_valid,
    output logic                    overrun,
    echo_delay_controller_if.master mem
);

    state_t            state;
    state_t            state_next;
    logic              armed;
    logic [DATA_W-1:0] hold;
    logic              accept;
    logic              ptr_clear;
    logic              ptr_advance;
    logic              ptr_load;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;

    echo_ring_pointer #(
        .ADDR_W (ADDR_W)
    ) u_ring_pointer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (ptr_clear),
        .advance   (ptr_advance),
        .load      (ptr_load),
        .delay_len (delay_len),
        .wp        (wp),
        .clr_cnt   (clr_cnt),
        .clr_last  (clr_last)
    );

    // armed keeps the RAM idle while reset is held; clearing starts on the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= CLEAR;
            armed         <= 1'b0;
            hold          <= '0;
            delayed_out   <= '0;
            delayed_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            armed         <= 1'b1;
            delayed_valid <= (state == XFER);
            if (accept) begin
                hold <= sample_in;
            end
            if (state == XFER) begin
                delayed_out <= mem.mem_rdata;
            end
            if (sample_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        accept        = 1'b0;
        ptr_clear     = 1'b0;
        ptr_advance   = 1'b0;
        ptr_load      = 1'b0;
        case (state)
            CLEAR: begin
                if (armed) begin
                    mem.mem_en   = 1'b1;
                    mem.mem_we   = 1'b1;
                    mem.mem_addr = clr_cnt;
                    ptr_clear    = 1'b1;
                    if (clr_last) begin
                        state_next = IDLE;
                    end
                end
            end
            IDLE: begin
                if (sample_valid) begin
                    accept     = 1'b1;
                    state_next = READ;
                end else if (cfg_load) begin
                    ptr_load = 1'b1;
                end
            end
            READ: begin
                mem.mem_en   = 1'b1;
                mem.mem_addr = wp;
                state_next   = XFER;
            end
            XFER: begin
                mem.mem_en    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = wp;
                mem.mem_wdata = hold;
                ptr_advance   = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/echo_delay_controller.md
Name: echo_delay_controller

Overview:
- Sequences a single-port RAM used as a circular delay line for the echo datapath. This replaces the fixed-length shift-register delay with a programmable one.
- Per sample strobe, it reads the oldest stored sample, writes the new feedback sample into the same slot, and presents the delayed sample to the echo adder.
- It also zero-fills the RAM after reset and applies delay-length changes only at sample boundaries.

Parameters:
- DATA_W, 16, sample width in bits (two's complement).
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- sample_in  in  DATA_W  feedback sample to store.
- delay_len  in  ADDR_W  requested delay in samples; 0 is treated as 1.
- cfg_load  in  1  one-cycle strobe; latch delay_len.
- busy  out  1  high when the FSM is not in IDLE.
- delayed_out  out  DATA_W  delayed sample, held between updates.
- delayed_valid  out  1  one-cycle pulse when delayed_out updates.
- overrun  out  1  sticky; a sample_valid was dropped.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after a read enable.

Behaviour:
- Reset (async assert, sync release):
  - State is CLEAR; wp=0; len=DEPTH-1.
  - delayed_out=0, delayed_valid=0, overrun=0, busy=1.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: CLEAR, IDLE, READ, XFER.
- CLEAR:
  - Each cycle: mem_en=1, mem_we=1, mem_wdata=0, mem_addr=clr_cnt; clr_cnt counts 0..DEPTH-1.
  - After writing address DEPTH-1, go to IDLE; clearing takes exactly DEPTH cycles.
- IDLE:
  - sample_valid: capture sample_in into hold register and go to READ.
  - cfg_load without sample_valid: len = (delay_len==0) ? 1 : delay_len. If wp >= new len, wp=0.
  - cfg_load and sample_valid in the same cycle: the sample wins and cfg_load is ignored.
- READ (cycle T+1 after a strobe at T): mem_en=1, mem_we=0, mem_addr=wp; go to XFER.
- XFER (T+2):
  - mem_en=1, mem_we=1, mem_addr=wp, mem_wdata=hold.
  - delayed_out<=mem_rdata; delayed_valid=1 at T+3.
  - wp = (wp+1 == len) ? 0 : wp+1; go to IDLE.
- Throughput: at most one sample every 3 cycles.
- sample_valid while busy (including CLEAR): the sample is dropped and overrun is set. overrun clears only on reset.
- cfg_load while busy: ignored; no pending latch.
- Delay: the value written at strobe k appears on delayed_out at strobe k+len.
- Pointer wrap: wp never reaches len; wraps to 0 at len-1. With len=1, wp stays 0 and the output equals the previous sample.
- mem_* outputs are 0 in IDLE.
- Reset mid-operation aborts any in-flight transfer, and the clear restarts from address 0.
- No arithmetic on data; scaling and addition remain in the echo datapath.

Decomposition:
- Shared package echo_pkg:
  - State encoding localparams: CLEAR=2'd0, IDLE=2'd1, READ=2'd2, XFER=2'd3.
  - Default DATA_W and ADDR_W.
- One natural sub-module, echo_ring_pointer, holding:
  - wp, len, and clr_cnt.
  - Wrap logic and config latch, with advance, load and clear inputs.
- The RAM itself is external and not part of this block.

Test Plan:
- Reset clear: ADDR_W=4; release reset_n -> exactly 16 cycles of mem_we=1, wdata=0, addr 0..15 in order; then busy=0.
- Basic delay: cfg_load delay_len=3; strobe samples 10,20,30,40,50,60 every 4 cycles -> delayed_out 0,0,0,10,20,30; each delayed_valid occurs 3 cycles after its strobe.
- len=1 and delay_len=0: load 0 -> behaves as len 1; inputs 5,-7 (0xFFF9) -> outputs 0,5.
- Overrun: strobe, then strobe 1 cycle later -> second sample dropped, overrun=1 and sticky, wp advanced once.
- Config shrink: len=8 with wp=6; cfg_load delay_len=4 -> wp=0; the next write goes to address 0. Also cfg_load during READ is ignored and len is unchanged.
- Async reset mid-XFER: assert reset_n=0 in XFER -> outputs go to reset values immediately, no delayed_valid, CLEAR restarts at address 0.
